// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: microcode step counter and control-word decoder for the 8-bit CPU.
// Every instruction runs a fixed two-step fetch (T0, T1) followed by opcode-specific
// execute steps from T2 onward. The control word is decoded combinationally from the
// registered step/halt state and the live opcode and flags.
module cpu_control_sequencer #(
  parameter int NUM_STEPS   = 5,
  parameter bit EARLY_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        flag_carry,
  input  logic        flag_zero,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] MAX_STEP = 3'(NUM_STEPS - 1);

  // Control word bit positions
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  // Opcode encodings
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [15:0] micro_word;
  logic [2:0]  last_step;

  // Decode the microinstruction for the current step, and the last non-empty step of the opcode
  always_comb begin
    micro_word = 16'h0000;
    last_step  = 3'd2;
    case (opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
    if (last_step > MAX_STEP) begin
      last_step = MAX_STEP;
    end
    case (step_q)
      3'd0: micro_word = C_CO | C_MI;
      3'd1: micro_word = C_RO | C_II | C_CE;
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: micro_word = C_IO | C_MI;
          OP_LDI: micro_word = C_IO | C_AI;
          OP_JMP: micro_word = C_IO | C_J;
          OP_JC:  micro_word = flag_carry ? (C_IO | C_J) : 16'h0000;
          OP_JZ:  micro_word = flag_zero ? (C_IO | C_J) : 16'h0000;
          OP_OUT: micro_word = C_AO | C_OI;
          OP_HLT: micro_word = C_HLT;
          default: micro_word = 16'h0000;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         micro_word = C_RO | C_AI;
          OP_ADD, OP_SUB: micro_word = C_RO | C_BI;
          OP_STA:         micro_word = C_AO | C_RI;
          default:        micro_word = 16'h0000;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD:  micro_word = C_EO | C_AI | C_FI;
          OP_SUB:  micro_word = C_EO | C_SU | C_AI | C_FI;
          default: micro_word = 16'h0000;
        endcase
      end
      default: micro_word = 16'h0000;
    endcase
  end

  // Halt overrides everything; a paused sequencer drives an empty word so nothing repeats
  always_comb begin
    ctrl = 16'h0000;
    if (halted_q) begin
      ctrl = C_HLT;
    end else if (run) begin
      ctrl = micro_word;
    end
  end

  // Next-state: advance, wrap or early-return the step counter, and latch halt at HLT's T2
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      if (step_q == 3'd2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q == MAX_STEP || (EARLY_RESET && step_q >= last_step)) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  // State registers; reset aborts any instruction in flight and restarts at fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign step   = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: drives two sequencers (normal and early-return step wrap)
// with directed and random stimulus and compares them to a microprogram-table model.
module tb_cpu_control_sequencer;

   localparam int NSTEPS = 5;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [3:0]  opcode;
   logic        flagCarry;
   logic        flagZero;
   logic [15:0] ctrlN, ctrlE;
   logic [2:0]  stepN, stepE;
   logic        haltedN, haltedE;

   int errCount;
   int checkCount;

   // Model state: index 0 = normal wrap, index 1 = early return
   int modelStep[2];
   bit modelHalt[2];

   cpu_control_sequencer #(.NUM_STEPS(NSTEPS), .EARLY_RESET(1'b0)) dutNormal (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
      .flag_carry(flagCarry), .flag_zero(flagZero),
      .ctrl(ctrlN), .step(stepN), .halted(haltedN)
   );

   cpu_control_sequencer #(.NUM_STEPS(NSTEPS), .EARLY_RESET(1'b1)) dutEarly (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
      .flag_carry(flagCarry), .flag_zero(flagZero),
      .ctrl(ctrlE), .step(stepE), .halted(haltedE)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of listed microsteps (fetch plus execute) for each opcode
   function automatic int progLen(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   // The microprogram for an opcode, one word per listed step
   function automatic logic [15:0] progWord(input logic [3:0] op, input logic c, input logic z, input int idx);
      logic [15:0] prog[5];
      prog = '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000};
      case (op)
         4'h1: begin prog[2] = 16'h4800; prog[3] = 16'h1200; end
         4'h2: begin prog[2] = 16'h4800; prog[3] = 16'h1020; prog[4] = 16'h0281; end
         4'h3: begin prog[2] = 16'h4800; prog[3] = 16'h1020; prog[4] = 16'h02C1; end
         4'h4: begin prog[2] = 16'h4800; prog[3] = 16'h2100; end
         4'h5: prog[2] = 16'h0A00;
         4'h6: prog[2] = 16'h0802;
         4'h7: prog[2] = c ? 16'h0802 : 16'h0000;
         4'h8: prog[2] = z ? 16'h0802 : 16'h0000;
         4'hE: prog[2] = 16'h0110;
         4'hF: prog[2] = 16'h8000;
         default: prog[2] = 16'h0000;
      endcase
      if (idx < progLen(op)) return prog[idx];
      return 16'h0000;
   endfunction

   function automatic logic [15:0] expCtrl(input int k);
      if (modelHalt[k]) return 16'h8000;
      if (!run) return 16'h0000;
      return progWord(opcode, flagCarry, flagZero, modelStep[k]);
   endfunction

   // Model step/halt update at a clock edge
   task automatic modelAdvance(input int k);
      if (modelHalt[k] || !run) return;
      if (modelStep[k] == 2 && opcode == 4'hF) begin
         modelHalt[k] = 1'b1;
      end else if (k == 1 && modelStep[k] >= progLen(opcode) - 1) begin
         modelStep[k] = 0;
      end else begin
         modelStep[k] = (modelStep[k] + 1) % NSTEPS;
      end
   endtask

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_ctrlN"}, ctrlN, expCtrl(0));
      checkOutput({tag, "_stepN"}, {13'd0, stepN}, 16'(modelStep[0]));
      checkOutput({tag, "_haltN"}, {15'd0, haltedN}, {15'd0, modelHalt[0]});
      checkOutput({tag, "_ctrlE"}, ctrlE, expCtrl(1));
      checkOutput({tag, "_stepE"}, {13'd0, stepE}, 16'(modelStep[1]));
      checkOutput({tag, "_haltE"}, {15'd0, haltedE}, {15'd0, modelHalt[1]});
   endtask

   // Drive inputs just after the falling edge and check the settled outputs
   task automatic applyStimulus(input string tag, input logic r, input logic [3:0] op, input logic c, input logic z);
      run       = r;
      opcode    = op;
      flagCarry = c;
      flagZero  = z;
      #1;
      checkAll(tag);
   endtask

   // Advance one clock and the model with it, returning to the falling edge
   task automatic clockEdge();
      @(posedge clk);
      modelAdvance(0);
      modelAdvance(1);
      @(negedge clk);
   endtask

   // Asynchronous reset applied mid-cycle; outputs must change before any clock edge
   task automatic doReset();
      run   = 1'b1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         modelStep[k] = 0;
         modelHalt[k] = 1'b0;
      end
      checkAll("reset");
      checkOutput("reset_ctrl_const", ctrlN, 16'h4004);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] ldaSeq[6];
      logic [3:0]  op;
      int haltCycles;
      errCount   = 0;
      checkCount = 0;
      rst_n      = 1'b0;
      run        = 1'b0;
      opcode     = 4'h0;
      flagCarry  = 1'b0;
      flagZero   = 1'b0;
      modelStep  = '{0, 0};
      modelHalt  = '{1'b0, 1'b0};
      @(negedge clk);
      doReset();

      // LDA on the normal sequencer: full sequence with wrap back to T0
      ldaSeq = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000, 16'h4004};
      for (int i = 0; i < 6; i++) begin
         applyStimulus("lda", 1'b1, 4'h1, 1'b0, 1'b0);
         checkOutput("lda_seq", ctrlN, ldaSeq[i]);
         clockEdge();
      end

      // ADD, SUB, then each jump type with both flag values
      doReset();
      for (int i = 0; i < 5; i++) begin applyStimulus("add", 1'b1, 4'h2, 1'b1, 1'b1); clockEdge(); end
      doReset();
      for (int i = 0; i < 5; i++) begin applyStimulus("sub", 1'b1, 4'h3, 1'b0, 1'b1); clockEdge(); end
      for (int f = 0; f < 4; f++) begin
         doReset();
         for (int i = 0; i < 5; i++) begin
            applyStimulus(f < 2 ? "jc" : "jz", 1'b1, f < 2 ? 4'h7 : 4'h8, f[0], f[0]);
            clockEdge();
         end
      end

      // Early-return opcodes: LDI, undefined, OUT, STA
      foreach (ldaSeq[i]) ldaSeq[i] = 16'h0;
      for (int j = 0; j < 4; j++) begin
         op = (j == 0) ? 4'h5 : (j == 1) ? 4'h9 : (j == 2) ? 4'hE : 4'h4;
         doReset();
         for (int i = 0; i < 6; i++) begin applyStimulus("early", 1'b1, op, 1'b0, 1'b0); clockEdge(); end
      end

      // Pause at T1 for five cycles, then resume for exactly one T1 word
      doReset();
      applyStimulus("pause_t0", 1'b1, 4'h0, 1'b0, 1'b0);
      clockEdge();
      for (int i = 0; i < 5; i++) begin
         applyStimulus("pause", 1'b0, 4'h0, 1'b0, 1'b0);
         checkOutput("pause_ctrl_const", ctrlN, 16'h0000);
         clockEdge();
      end
      applyStimulus("resume", 1'b1, 4'h0, 1'b0, 1'b0);
      checkOutput("resume_ctrl_const", ctrlN, 16'h1408);
      clockEdge();
      applyStimulus("resume_next", 1'b1, 4'h0, 1'b0, 1'b0);
      checkOutput("resume_step_const", {13'd0, stepN}, 16'd2);
      clockEdge();

      // Halt, then hold with random inputs for twenty cycles
      doReset();
      for (int i = 0; i < 3; i++) begin applyStimulus("hlt", 1'b1, 4'hF, 1'b0, 1'b0); clockEdge(); end
      for (int i = 0; i < 20; i++) begin
         applyStimulus("halted", 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
         checkOutput("halted_ctrl_const", ctrlN, 16'h8000);
         clockEdge();
      end
      doReset();

      // Random traffic; HLT made rare and recovered with a reset after a few cycles
      haltCycles = 0;
      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom);
         if (op == 4'hF && $urandom_range(3, 0) != 0) op = 4'h0;
         applyStimulus("rand", ($urandom_range(7, 0) != 0), op, 1'($urandom), 1'($urandom));
         clockEdge();
         if (modelHalt[0] || modelHalt[1]) haltCycles++;
         if (haltCycles > 3 || $urandom_range(63, 0) == 0) begin
            haltCycles = 0;
            doReset();
         end
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
